// File: rtl/id_stage_hazard_if.sv
// Bundle of the ID-stage connections: IF/ID register, controller decode, WB/MEM feedback, hazard outputs and ID/EX register.
// The pipeline (or a testbench) drives through master; the ID stage attaches through slave.
interface id_stage_hazard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              if_valid;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] pc_plus4;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [1:0]        ctrl_regdst;
    logic              ctrl_ext_sign;
    logic              ctrl_branch;
    logic              ctrl_bne;
    logic              ctrl_mem_read;
    logic              ctrl_reg_write;
    logic              wb_reg_write;
    logic [ADDR_W-1:0] wb_write_reg;
    logic [DATA_W-1:0] wb_write_data;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic [ADDR_W-1:0] mem_write_reg;
    logic [DATA_W-1:0] mem_alu_result;
    logic              flush;
    logic              stall_if;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic              idex_valid;
    logic              idex_reg_write;
    logic              idex_mem_read;
    logic [DATA_W-1:0] idex_rs_data;
    logic [DATA_W-1:0] idex_rt_data;
    logic [DATA_W-1:0] idex_imm;
    logic [ADDR_W-1:0] idex_rs;
    logic [ADDR_W-1:0] idex_rt;
    logic [ADDR_W-1:0] idex_write_reg;
    logic [5:0]        idex_func;

    modport master (
        output if_valid, instruction, pc_plus4, ctrl_regdst, ctrl_ext_sign, ctrl_branch,
               ctrl_bne, ctrl_mem_read, ctrl_reg_write, wb_reg_write, wb_write_reg,
               wb_write_data, mem_reg_write, mem_mem_read, mem_write_reg, mem_alu_result, flush,
        input  opcode, func, stall_if, branch_taken, branch_target, idex_valid, idex_reg_write,
               idex_mem_read, idex_rs_data, idex_rt_data, idex_imm, idex_rs, idex_rt,
               idex_write_reg, idex_func
    );

    modport slave (
        input  if_valid, instruction, pc_plus4, ctrl_regdst, ctrl_ext_sign, ctrl_branch,
               ctrl_bne, ctrl_mem_read, ctrl_reg_write, wb_reg_write, wb_write_reg,
               wb_write_data, mem_reg_write, mem_mem_read, mem_write_reg, mem_alu_result, flush,
        output opcode, func, stall_if, branch_taken, branch_target, idex_valid, idex_reg_write,
               idex_mem_read, idex_rs_data, idex_rt_data, idex_imm, idex_rs, idex_rt,
               idex_write_reg, idex_func
    );
endinterface

// File: rtl/id_stage_hazard.sv
// MIPS decode stage: register file with write-through, immediate extension, early branch resolve,
// load-use/branch hazard detection and the ID/EX register. Define ID_BRANCH_FWD_EN to forward EX/MEM ALU results to the branch comparator.
module id_stage_hazard #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int LINK_REG = 31
) (
    input logic             clk,
    input logic             rst,
    id_stage_hazard_if.slave bus
);
    localparam int ADDR_W = ($clog2(NREGS) < 5) ? 5 : $clog2(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rs_data, rt_data, op_a, op_b, imm_ext;
    logic              load_use, br_ex, br_mem_load, br_mem_alu;
    logic              mem_alu_hit_rs, mem_alu_hit_rt, eq, stall, bubble;

    logic              idex_valid_q, idex_valid_d;
    logic              idex_reg_write_q, idex_reg_write_d;
    logic              idex_mem_read_q, idex_mem_read_d;
    logic [DATA_W-1:0] idex_rs_data_q, idex_rs_data_d;
    logic [DATA_W-1:0] idex_rt_data_q, idex_rt_data_d;
    logic [DATA_W-1:0] idex_imm_q, idex_imm_d;
    logic [ADDR_W-1:0] idex_rs_q, idex_rs_d;
    logic [ADDR_W-1:0] idex_rt_q, idex_rt_d;
    logic [ADDR_W-1:0] idex_write_reg_q, idex_write_reg_d;
    logic [5:0]        idex_func_q, idex_func_d;

    function automatic logic src_match(input logic [ADDR_W-1:0] dst, a, b);
        return ((a != '0) && (dst == a)) || ((b != '0) && (dst == b));
    endfunction

    assign rs          = ADDR_W'(bus.instruction[25:21]);
    assign rt          = ADDR_W'(bus.instruction[20:16]);
    assign rd          = ADDR_W'(bus.instruction[15:11]);
    assign bus.opcode  = bus.instruction[31:26];
    assign bus.func    = bus.instruction[5:0];

    assign imm_ext = bus.ctrl_ext_sign ? {{(DATA_W-16){bus.instruction[15]}}, bus.instruction[15:0]}
                                       : {{(DATA_W-16){1'b0}}, bus.instruction[15:0]};
    assign bus.branch_target = bus.pc_plus4 + (imm_ext << 2);

    // Same-cycle WB write is visible to the read so WB never causes a hazard.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs != '0 && int'(rs) < NREGS)
            rs_data = (bus.wb_reg_write && bus.wb_write_reg == rs) ? bus.wb_write_data : regs_q[rs];
        if (rt != '0 && int'(rt) < NREGS)
            rt_data = (bus.wb_reg_write && bus.wb_write_reg == rt) ? bus.wb_write_data : regs_q[rt];
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.wb_reg_write && bus.wb_write_reg != '0 && int'(bus.wb_write_reg) < NREGS)
            regs_d[bus.wb_write_reg] = bus.wb_write_data;
    end

    assign mem_alu_hit_rs = bus.mem_reg_write && !bus.mem_mem_read && rs != '0 && bus.mem_write_reg == rs;
    assign mem_alu_hit_rt = bus.mem_reg_write && !bus.mem_mem_read && rt != '0 && bus.mem_write_reg == rt;

`ifdef ID_BRANCH_FWD_EN
    assign op_a       = mem_alu_hit_rs ? bus.mem_alu_result : rs_data;
    assign op_b       = mem_alu_hit_rt ? bus.mem_alu_result : rt_data;
    assign br_mem_alu = 1'b0;
`else
    // Without the forwarding mux the branch waits one cycle for the value to reach WB.
    assign op_a       = rs_data;
    assign op_b       = rt_data;
    assign br_mem_alu = bus.ctrl_branch && (mem_alu_hit_rs || mem_alu_hit_rt);
`endif

    assign load_use    = idex_valid_q && idex_mem_read_q && src_match(idex_write_reg_q, rs, rt);
    assign br_ex       = bus.ctrl_branch && idex_valid_q && idex_reg_write_q && src_match(idex_write_reg_q, rs, rt);
    assign br_mem_load = bus.ctrl_branch && bus.mem_mem_read && bus.mem_reg_write
                         && src_match(bus.mem_write_reg, rs, rt);

    assign stall            = bus.if_valid && !bus.flush && (load_use || br_ex || br_mem_load || br_mem_alu);
    assign eq               = (op_a == op_b);
    assign bus.stall_if     = stall;
    assign bus.branch_taken = bus.if_valid && bus.ctrl_branch && !stall && !bus.flush
                              && (bus.ctrl_bne ? !eq : eq);
    assign bubble           = bus.flush || stall || !bus.if_valid;

    always_comb begin
        idex_valid_d     = !bubble;
        idex_reg_write_d = !bubble && bus.ctrl_reg_write;
        idex_mem_read_d  = !bubble && bus.ctrl_mem_read;
        idex_rs_data_d   = rs_data;
        idex_rt_data_d   = rt_data;
        idex_imm_d       = imm_ext;
        idex_rs_d        = rs;
        idex_rt_d        = rt;
        idex_func_d      = bus.instruction[5:0];
        case (bus.ctrl_regdst)
            2'd1:    idex_write_reg_d = rd;
            2'd2:    idex_write_reg_d = ADDR_W'(LINK_REG);
            default: idex_write_reg_d = rt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q           <= '{default: '0};
            idex_valid_q     <= 1'b0;
            idex_reg_write_q <= 1'b0;
            idex_mem_read_q  <= 1'b0;
            idex_rs_data_q   <= '0;
            idex_rt_data_q   <= '0;
            idex_imm_q       <= '0;
            idex_rs_q        <= '0;
            idex_rt_q        <= '0;
            idex_write_reg_q <= '0;
            idex_func_q      <= '0;
        end else begin
            regs_q           <= regs_d;
            idex_valid_q     <= idex_valid_d;
            idex_reg_write_q <= idex_reg_write_d;
            idex_mem_read_q  <= idex_mem_read_d;
            idex_rs_data_q   <= idex_rs_data_d;
            idex_rt_data_q   <= idex_rt_data_d;
            idex_imm_q       <= idex_imm_d;
            idex_rs_q        <= idex_rs_d;
            idex_rt_q        <= idex_rt_d;
            idex_write_reg_q <= idex_write_reg_d;
            idex_func_q      <= idex_func_d;
        end
    end

    assign bus.idex_valid     = idex_valid_q;
    assign bus.idex_reg_write = idex_reg_write_q;
    assign bus.idex_mem_read  = idex_mem_read_q;
    assign bus.idex_rs_data   = idex_rs_data_q;
    assign bus.idex_rt_data   = idex_rt_data_q;
    assign bus.idex_imm       = idex_imm_q;
    assign bus.idex_rs        = idex_rs_q;
    assign bus.idex_rt        = idex_rt_q;
    assign bus.idex_write_reg = idex_write_reg_q;
    assign bus.idex_func      = idex_func_q;
endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: directed scenarios plus randomized cycles checked against a rule-level model.
// A second instance with NREGS=64 covers the wide-address register file and link register.
module tb_id_stage_hazard;
`ifdef ID_BRANCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_hazard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    id_stage_hazard_if #(.DATA_W(32), .ADDR_W(6)) big_bus ();

    id_stage_hazard #(.DATA_W(32), .NREGS(32), .LINK_REG(31)) dut (.clk(clk), .rst(rst), .bus(bus));
    id_stage_hazard #(.DATA_W(32), .NREGS(64), .LINK_REG(31)) dut_big (.clk(clk), .rst(rst), .bus(big_bus));

    typedef struct {
        logic        rst_n, if_valid, ext_sign, branch, bne, mem_read, reg_write;
        logic [31:0] instr, pc4;
        logic [1:0]  regdst;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        mem_rw, mem_mr;
        logic [4:0]  mem_wr;
        logic [31:0] mem_alu;
        logic        flush;
    } stim_t;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers and the expected ID/EX contents.
    logic [31:0] m_regs [32];
    logic        m_valid = 1'b0, m_rw = 1'b0, m_mr = 1'b0, m_full = 1'b0;
    logic [4:0]  m_wr = '0, m_rs = '0, m_rt = '0;
    logic [31:0] m_rsd = '0, m_rtd = '0, m_imm = '0;
    logic [5:0]  m_func = '0;
    logic        obs_stall, obs_taken;
    logic [31:0] obs_target;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input stim_t s, input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (s.wb_we && s.wb_addr == a) return s.wb_data;
        return m_regs[a];
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst_n: 1'b1, if_valid: 1'b0, ext_sign: 1'b0, branch: 1'b0, bne: 1'b0, mem_read: 1'b0,
              reg_write: 1'b0, instr: 32'h0, pc4: 32'h0, regdst: 2'd0, wb_we: 1'b0, wb_addr: 5'd0,
              wb_data: 32'h0, mem_rw: 1'b0, mem_mr: 1'b0, mem_wr: 5'd0, mem_alu: 32'h0, flush: 1'b0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = nop();
        s.rst_n          = ($urandom_range(0, 39) != 0);
        s.if_valid       = ($urandom_range(0, 3) != 0);
        s.instr          = $urandom;
        s.instr[25:21]   = 5'($urandom_range(0, 7));
        s.instr[20:16]   = 5'($urandom_range(0, 7));
        s.instr[15:11]   = 5'($urandom_range(0, 7));
        s.pc4            = $urandom;
        s.regdst         = 2'($urandom_range(0, 3));
        s.ext_sign       = 1'($urandom);
        s.branch         = 1'($urandom);
        s.bne            = 1'($urandom);
        s.mem_read       = 1'($urandom);
        s.reg_write      = 1'($urandom);
        s.wb_we          = 1'($urandom);
        s.wb_addr        = 5'($urandom_range(0, 7));
        s.wb_data        = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
        s.mem_rw         = 1'($urandom);
        s.mem_mr         = 1'($urandom);
        s.mem_wr         = 5'($urandom_range(0, 7));
        s.mem_alu        = 32'($urandom_range(0, 3));
        s.flush          = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // Drive one cycle, check the combinational outputs before the edge and ID/EX after it.
    task automatic applyStimulus(input stim_t s);
        logic [4:0]  rs, rt, rd, n_wr;
        logic [31:0] rs_val, rt_val, a, b, imm, target;
        logic        needs_ex, needs_mem, exp_stall, exp_taken, hold;

        rs = s.instr[25:21];
        rt = s.instr[20:16];
        rd = s.instr[15:11];

        rst                    = s.rst_n;
        bus.if_valid           = s.if_valid;
        bus.instruction        = s.instr;
        bus.pc_plus4           = s.pc4;
        bus.ctrl_regdst        = s.regdst;
        bus.ctrl_ext_sign      = s.ext_sign;
        bus.ctrl_branch        = s.branch;
        bus.ctrl_bne           = s.bne;
        bus.ctrl_mem_read      = s.mem_read;
        bus.ctrl_reg_write     = s.reg_write;
        bus.wb_reg_write       = s.wb_we;
        bus.wb_write_reg       = s.wb_addr;
        bus.wb_write_data      = s.wb_data;
        bus.mem_reg_write      = s.mem_rw;
        bus.mem_mem_read       = s.mem_mr;
        bus.mem_write_reg      = s.mem_wr;
        bus.mem_alu_result     = s.mem_alu;
        bus.flush              = s.flush;
        #2;
        obs_stall  = bus.stall_if;
        obs_taken  = bus.branch_taken;
        obs_target = bus.branch_target;

        rs_val    = model_read(s, rs);
        rt_val    = model_read(s, rt);
        imm       = s.ext_sign ? {{16{s.instr[15]}}, s.instr[15:0]} : {16'h0, s.instr[15:0]};
        target    = s.pc4 + imm * 4;
        needs_ex  = (m_wr != 0) && (m_wr == rs || m_wr == rt);
        needs_mem = (s.mem_wr != 0) && (s.mem_wr == rs || s.mem_wr == rt);
        exp_stall = s.if_valid && !s.flush &&
                    ((m_valid && m_mr && needs_ex) ||
                     (s.branch && m_valid && m_rw && needs_ex) ||
                     (s.branch && s.mem_rw && needs_mem && (s.mem_mr || !FWD)));
        a = (FWD && s.mem_rw && !s.mem_mr && rs != 0 && s.mem_wr == rs) ? s.mem_alu : rs_val;
        b = (FWD && s.mem_rw && !s.mem_mr && rt != 0 && s.mem_wr == rt) ? s.mem_alu : rt_val;
        exp_taken = s.if_valid && s.branch && !exp_stall && !s.flush && ((a == b) != s.bne);

        checkOutput("stall_if", obs_stall, exp_stall);
        checkOutput("branch_taken", obs_taken, exp_taken);
        checkOutput("branch_target", obs_target, target);
        checkOutput("opcode", bus.opcode, s.instr[31:26]);
        checkOutput("func", bus.func, s.instr[5:0]);

        n_wr = (s.regdst == 2'd1) ? rd : (s.regdst == 2'd2) ? 5'd31 : rt;
        hold = s.flush || exp_stall || !s.if_valid;

        @(posedge clk);
        #1;
        if (!s.rst_n) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            {m_valid, m_rw, m_mr, m_wr, m_rs, m_rt, m_rsd, m_rtd, m_imm, m_func} = '0;
            m_full = 1'b1;
        end else begin
            if (s.wb_we && s.wb_addr != 0) m_regs[s.wb_addr] = s.wb_data;
            m_valid = !hold;
            m_rw    = !hold && s.reg_write;
            m_mr    = !hold && s.mem_read;
            m_wr    = n_wr;
            m_rs    = rs;
            m_rt    = rt;
            m_rsd   = rs_val;
            m_rtd   = rt_val;
            m_imm   = imm;
            m_func  = s.instr[5:0];
            m_full  = !hold;
        end

        checkOutput("idex_valid", bus.idex_valid, m_valid);
        checkOutput("idex_reg_write", bus.idex_reg_write, m_rw);
        checkOutput("idex_mem_read", bus.idex_mem_read, m_mr);
        if (m_full) begin
            checkOutput("idex_rs", bus.idex_rs, m_rs);
            checkOutput("idex_rt", bus.idex_rt, m_rt);
            checkOutput("idex_write_reg", bus.idex_write_reg, m_wr);
            checkOutput("idex_rs_data", bus.idex_rs_data, m_rsd);
            checkOutput("idex_rt_data", bus.idex_rt_data, m_rtd);
            checkOutput("idex_imm", bus.idex_imm, m_imm);
            checkOutput("idex_func", bus.idex_func, m_func);
        end
    endtask

    initial begin
        stim_t s;
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        big_bus.if_valid = 1'b0;        big_bus.instruction = '0;     big_bus.pc_plus4 = '0;
        big_bus.ctrl_regdst = '0;       big_bus.ctrl_ext_sign = 1'b0; big_bus.ctrl_branch = 1'b0;
        big_bus.ctrl_bne = 1'b0;        big_bus.ctrl_mem_read = 1'b0; big_bus.ctrl_reg_write = 1'b0;
        big_bus.wb_reg_write = 1'b0;    big_bus.wb_write_reg = '0;    big_bus.wb_write_data = '0;
        big_bus.mem_reg_write = 1'b0;   big_bus.mem_mem_read = 1'b0;  big_bus.mem_write_reg = '0;
        big_bus.mem_alu_result = '0;    big_bus.flush = 1'b0;

        $display("[TB] reset");
        s = nop(); s.rst_n = 1'b0;
        applyStimulus(s);
        checkOutput("reset_idex_valid", bus.idex_valid, 1'b0);
        checkOutput("reset_idex_rs_data", bus.idex_rs_data, 32'h0);
        checkOutput("reset_stall", obs_stall, 1'b0);

        $display("[TB] write-through and r0");
        s = nop(); s.if_valid = 1'b1; s.instr = {6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20};
        s.regdst = 2'd1; s.reg_write = 1'b1;
        s.wb_we = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'hDEADBEEF;
        applyStimulus(s);
        checkOutput("wt_bypass", bus.idex_rs_data, 32'hDEADBEEF);
        s.instr[25:21] = 5'd0; s.wb_addr = 5'd0; s.wb_data = 32'h1234;
        applyStimulus(s);
        checkOutput("r0_write_bypass", bus.idex_rs_data, 32'h0);
        s.wb_we = 1'b0;
        applyStimulus(s);
        checkOutput("r0_read", bus.idex_rs_data, 32'h0);

        $display("[TB] load-use");
        s = nop(); s.if_valid = 1'b1; s.instr = {6'h23, 5'd1, 5'd8, 16'h0004};
        s.mem_read = 1'b1; s.reg_write = 1'b1; s.ext_sign = 1'b1;
        applyStimulus(s);
        s = nop(); s.if_valid = 1'b1; s.instr = {6'h00, 5'd1, 5'd8, 5'd9, 5'd0, 6'h20};
        s.regdst = 2'd1; s.reg_write = 1'b1;
        applyStimulus(s);
        checkOutput("lu_stall", obs_stall, 1'b1);
        checkOutput("lu_bubble", bus.idex_valid, 1'b0);
        applyStimulus(s);
        checkOutput("lu_release", obs_stall, 1'b0);
        checkOutput("lu_issue_valid", bus.idex_valid, 1'b1);
        checkOutput("lu_issue_wr", bus.idex_write_reg, 5'd9);

        $display("[TB] beq/bne");
        s = nop(); s.wb_we = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'd7;
        applyStimulus(s);
        s.wb_addr = 5'd4;
        applyStimulus(s);
        s = nop(); s.if_valid = 1'b1; s.instr = {6'h04, 5'd3, 5'd4, 16'hFFFE};
        s.branch = 1'b1; s.ext_sign = 1'b1; s.pc4 = 32'h100;
        applyStimulus(s);
        checkOutput("beq_taken", obs_taken, 1'b1);
        checkOutput("beq_target", obs_target, 32'hF8);
        s.bne = 1'b1;
        applyStimulus(s);
        checkOutput("bne_not_taken", obs_taken, 1'b0);

        $display("[TB] branch after ALU op in MEM");
        s = nop(); s.wb_we = 1'b1; s.wb_addr = 5'd2; s.wb_data = 32'd1;
        applyStimulus(s);
        s.wb_addr = 5'd10; s.wb_data = 32'd9;
        applyStimulus(s);
        s = nop(); s.if_valid = 1'b1; s.instr = {6'h04, 5'd2, 5'd10, 16'h0010};
        s.branch = 1'b1; s.ext_sign = 1'b1; s.pc4 = 32'h200;
        s.mem_rw = 1'b1; s.mem_wr = 5'd2; s.mem_alu = 32'd9;
        applyStimulus(s);
`ifdef ID_BRANCH_FWD_EN
        checkOutput("fwd_no_stall", obs_stall, 1'b0);
        checkOutput("fwd_taken", obs_taken, 1'b1);
`else
        checkOutput("nofwd_stall", obs_stall, 1'b1);
        checkOutput("nofwd_wait", obs_taken, 1'b0);
        s.mem_rw = 1'b0; s.wb_we = 1'b1; s.wb_addr = 5'd2; s.wb_data = 32'd9;
        applyStimulus(s);
        checkOutput("nofwd_release", obs_stall, 1'b0);
        checkOutput("nofwd_taken", obs_taken, 1'b1);
`endif

        $display("[TB] flush over hazard");
        s = nop(); s.if_valid = 1'b1; s.instr = {6'h23, 5'd1, 5'd8, 16'h0000};
        s.mem_read = 1'b1; s.reg_write = 1'b1;
        applyStimulus(s);
        s = nop(); s.if_valid = 1'b1; s.instr = {6'h04, 5'd8, 5'd8, 16'h0004};
        s.branch = 1'b1; s.flush = 1'b1;
        applyStimulus(s);
        checkOutput("flush_stall", obs_stall, 1'b0);
        checkOutput("flush_taken", obs_taken, 1'b0);
        checkOutput("flush_bubble", bus.idex_valid, 1'b0);

        $display("[TB] randomized cycles");
        for (int i = 0; i < 400; i++) applyStimulus(rand_stim());

        $display("[TB] NREGS=64 instance");
        rst = 1'b1;
        big_bus.wb_reg_write = 1'b1; big_bus.wb_write_reg = 6'd63; big_bus.wb_write_data = 32'hAAAA;
        @(posedge clk); #1;
        big_bus.wb_write_reg = 6'd31; big_bus.wb_write_data = 32'h5555;
        @(posedge clk); #1;
        big_bus.wb_reg_write = 1'b0;
        big_bus.if_valid = 1'b1; big_bus.instruction = {6'h03, 5'd31, 5'd0, 16'h0040};
        big_bus.ctrl_regdst = 2'd2; big_bus.ctrl_reg_write = 1'b1;
        @(posedge clk); #1;
        checkOutput("big_valid", big_bus.idex_valid, 1'b1);
        checkOutput("big_link_reg", big_bus.idex_write_reg, 6'd31);
        checkOutput("big_r31_read", big_bus.idex_rs_data, 32'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
